// File: rtl/pwm_regs_pkg.sv
// Shared register-map constants for the double-buffered PWM register bank.
package pwm_regs_pkg;

  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_PRESCALE = 1;
  localparam int ADDR_UPDATE   = 2;
  localparam int ADDR_STATUS   = 3;
  localparam int ADDR_IRQ_MASK = 4;
  localparam int ADDR_CH_BASE  = 5;

  // Each channel owns a period/duty pair of consecutive addresses.
  function automatic int period_addr(input int ch);
    return ADDR_CH_BASE + 2 * ch;
  endfunction

  function automatic int duty_addr(input int ch);
    return ADDR_CH_BASE + 2 * ch + 1;
  endfunction

endpackage

// File: rtl/pwm_shadow_ch.sv
// One PWM channel's shadow/active period and duty pair with its commit-pending flag.
module pwm_shadow_ch #(
  parameter int REG_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 period_wr,
  input  logic                 duty_wr,
  input  logic [REG_WIDTH-1:0] wdata,
  input  logic                 update_set,
  input  logic                 period_end,
  input  logic                 ch_en,
  input  logic                 glob_en,
  output logic [REG_WIDTH-1:0] shadow_period,
  output logic [REG_WIDTH-1:0] shadow_duty,
  output logic [REG_WIDTH-1:0] active_period,
  output logic [REG_WIDTH-1:0] active_duty,
  output logic                 pending,
  output logic                 load
);

  logic [REG_WIDTH-1:0] sh_period_q, sh_period_d;
  logic [REG_WIDTH-1:0] sh_duty_q, sh_duty_d;
  logic [REG_WIDTH-1:0] act_period_q, act_period_d;
  logic [REG_WIDTH-1:0] act_duty_q, act_duty_d;
  logic [REG_WIDTH-1:0] clamped_duty;
  logic                 pending_q, pending_d;

  always_comb begin
    // A stopped channel has no boundary to wait for, so it loads immediately.
    load         = pending_q && (period_end || !ch_en || !glob_en);
    clamped_duty = (sh_duty_q > sh_period_q) ? sh_period_q : sh_duty_q;

    sh_period_d  = period_wr ? wdata : sh_period_q;
    sh_duty_d    = duty_wr ? wdata : sh_duty_q;
    act_period_d = load ? sh_period_q : act_period_q;
    act_duty_d   = load ? clamped_duty : act_duty_q;
    // A fresh request arriving with a load re-arms for the next boundary.
    pending_d    = (pending_q && !load) || update_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_period_q  <= '0;
      sh_duty_q    <= '0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      pending_q    <= 1'b0;
    end else begin
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      pending_q    <= pending_d;
    end
  end

  assign shadow_period = sh_period_q;
  assign shadow_duty   = sh_duty_q;
  assign active_period = act_period_q;
  assign active_duty   = act_duty_q;
  assign pending       = pending_q;

endmodule

// File: rtl/pwm_regs_shadow.sv
// PWM register bank with per-channel double-buffered period/duty and W1C load status.
// Optional interrupt output enabled by defining PWM_REGS_IRQ_EN.
module pwm_regs_shadow
  import pwm_regs_pkg::*;
#(
  parameter  int REG_WIDTH    = 16,
  parameter  int NUM_CHANNELS = 4,
  localparam int DEPTH        = ADDR_CH_BASE + 2 * NUM_CHANNELS,
  localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              write_en,
  input  logic [ADDR_WIDTH-1:0]             write_addr,
  input  logic [REG_WIDTH-1:0]              write_data,
  output logic                              write_ack,
  output logic                              write_err,
  input  logic                              read_en,
  input  logic [ADDR_WIDTH-1:0]             read_addr,
  output logic [REG_WIDTH-1:0]              read_data,
  output logic                              read_valid,
  output logic                              read_err,
  input  logic [NUM_CHANNELS-1:0]           period_end,
  output logic [REG_WIDTH-1:0]              prescale,
  output logic [NUM_CHANNELS*REG_WIDTH-1:0] period,
  output logic [NUM_CHANNELS*REG_WIDTH-1:0] duty,
  output logic [NUM_CHANNELS:0]             pwm_enable_reg,
  output logic                              irq
);

  logic [NUM_CHANNELS:0]   ctrl_q, ctrl_d;
  logic [REG_WIDTH-1:0]    prescale_q, prescale_d;
  logic [NUM_CHANNELS-1:0] status_q, status_d;
  logic                    ack_q, ack_d;
  logic                    werr_q, werr_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rerr_q, rerr_d;
  logic [REG_WIDTH-1:0]    rdata_q, rdata_d;

  logic                    wr_in_range, rd_in_range;
  logic                    update_wr, status_wr;
  logic [NUM_CHANNELS-1:0] w1c_mask;
  logic [NUM_CHANNELS-1:0] pending;
  logic [NUM_CHANNELS-1:0] load;
  logic [NUM_CHANNELS-1:0] irq_mask_val;
  logic [REG_WIDTH-1:0]    sh_period [NUM_CHANNELS];
  logic [REG_WIDTH-1:0]    sh_duty   [NUM_CHANNELS];
  logic [REG_WIDTH-1:0]    rd_val;

  assign wr_in_range = int'(write_addr) < DEPTH;
  assign rd_in_range = int'(read_addr) < DEPTH;
  assign update_wr   = write_en && (write_addr == ADDR_WIDTH'(ADDR_UPDATE));
  assign status_wr   = write_en && (write_addr == ADDR_WIDTH'(ADDR_STATUS));
  assign w1c_mask    = status_wr ? write_data[NUM_CHANNELS-1:0] : '0;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    pwm_shadow_ch #(
      .REG_WIDTH(REG_WIDTH)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .period_wr    (write_en && (write_addr == ADDR_WIDTH'(period_addr(i)))),
      .duty_wr      (write_en && (write_addr == ADDR_WIDTH'(duty_addr(i)))),
      .wdata        (write_data),
      .update_set   (update_wr && write_data[i]),
      .period_end   (period_end[i]),
      .ch_en        (ctrl_q[i+1]),
      .glob_en      (ctrl_q[0]),
      .shadow_period(sh_period[i]),
      .shadow_duty  (sh_duty[i]),
      .active_period(period[i*REG_WIDTH +: REG_WIDTH]),
      .active_duty  (duty[i*REG_WIDTH +: REG_WIDTH]),
      .pending      (pending[i]),
      .load         (load[i])
    );
  end

  always_comb begin
    rd_val = '0;
    if (read_addr == ADDR_WIDTH'(ADDR_CTRL))     rd_val = REG_WIDTH'(ctrl_q);
    if (read_addr == ADDR_WIDTH'(ADDR_PRESCALE)) rd_val = prescale_q;
    if (read_addr == ADDR_WIDTH'(ADDR_UPDATE))   rd_val = REG_WIDTH'(pending);
    if (read_addr == ADDR_WIDTH'(ADDR_STATUS))   rd_val = REG_WIDTH'(status_q);
    if (read_addr == ADDR_WIDTH'(ADDR_IRQ_MASK)) rd_val = REG_WIDTH'(irq_mask_val);
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (read_addr == ADDR_WIDTH'(period_addr(i))) rd_val = sh_period[i];
      if (read_addr == ADDR_WIDTH'(duty_addr(i)))   rd_val = sh_duty[i];
    end
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    if (write_en && (write_addr == ADDR_WIDTH'(ADDR_CTRL)))     ctrl_d = write_data[NUM_CHANNELS:0];
    if (write_en && (write_addr == ADDR_WIDTH'(ADDR_PRESCALE))) prescale_d = write_data;
    // Load sets are applied after the clear so a coincident W1C cannot hide a load.
    status_d   = (status_q & ~w1c_mask) | load;
    ack_d      = write_en;
    werr_d     = write_en && !wr_in_range;
    rvalid_d   = read_en;
    rerr_d     = read_en && !rd_in_range;
    rdata_d    = (read_en && rd_in_range) ? rd_val : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      status_q   <= '0;
      ack_q      <= 1'b0;
      werr_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rerr_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      status_q   <= status_d;
      ack_q      <= ack_d;
      werr_q     <= werr_d;
      rvalid_q   <= rvalid_d;
      rerr_q     <= rerr_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef PWM_REGS_IRQ_EN
  logic [NUM_CHANNELS-1:0] irq_mask_q, irq_mask_d;
  logic                    irq_q, irq_d;

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (write_en && (write_addr == ADDR_WIDTH'(ADDR_IRQ_MASK))) irq_mask_d = write_data[NUM_CHANNELS-1:0];
    irq_d = |(status_q & irq_mask_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_mask_val = irq_mask_q;
  assign irq          = irq_q;
`else
  assign irq_mask_val = '0;
  assign irq          = 1'b0;
`endif

  assign write_ack      = ack_q;
  assign write_err      = werr_q;
  assign read_valid     = rvalid_q;
  assign read_err       = rerr_q;
  assign read_data      = rdata_q;
  assign prescale       = prescale_q;
  assign pwm_enable_reg = ctrl_q;

endmodule

// File: tb/tb_pwm_regs_shadow.sv
// Bench for pwm_regs_shadow: reset/read table, directed commit corner cases, and
// randomized traffic checked every cycle against a register-map reference model.
module tb_pwm_regs_shadow;

  localparam int RW    = 16;
  localparam int NCH   = 4;
  localparam int DEPTH = 5 + 2 * NCH;
  localparam int AW    = $clog2(DEPTH);
`ifdef PWM_REGS_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              w_en = 1'b0;
  logic [AW-1:0]     w_addr = '0;
  logic [RW-1:0]     w_data = '0;
  logic              r_en = 1'b0;
  logic [AW-1:0]     r_addr = '0;
  logic [NCH-1:0]    pe = '0;
  logic              write_ack, write_err, read_valid, read_err, irq;
  logic [RW-1:0]     read_data, prescale;
  logic [NCH*RW-1:0] period, duty;
  logic [NCH:0]      pwm_enable_reg;

  int total = 0;
  int bad = 0;

  pwm_regs_shadow #(.REG_WIDTH(RW), .NUM_CHANNELS(NCH)) dut (
    .clk(clk), .rst_n(rst_n),
    .write_en(w_en), .write_addr(w_addr), .write_data(w_data),
    .write_ack(write_ack), .write_err(write_err),
    .read_en(r_en), .read_addr(r_addr), .read_data(read_data),
    .read_valid(read_valid), .read_err(read_err),
    .period_end(pe), .prescale(prescale), .period(period), .duty(duty),
    .pwm_enable_reg(pwm_enable_reg), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: register contents as plain integers.
  int unsigned m_ctrl, m_pre, m_pend, m_status, m_mask;
  int unsigned m_sp[NCH], m_sd[NCH], m_ap[NCH], m_ad[NCH];
  bit          exp_ack, exp_werr, exp_rv, exp_rerr, exp_irq;
  int unsigned exp_rdata;

  task automatic m_reset();
    m_ctrl = 0; m_pre = 0; m_pend = 0; m_status = 0; m_mask = 0;
    for (int i = 0; i < NCH; i++) begin
      m_sp[i] = 0; m_sd[i] = 0; m_ap[i] = 0; m_ad[i] = 0;
    end
    exp_ack = 0; exp_werr = 0; exp_rv = 0; exp_rerr = 0; exp_irq = 0; exp_rdata = 0;
  endtask

  function automatic int unsigned m_reg(input int unsigned a);
    int unsigned v;
    v = 0;
    if (a == 0) v = m_ctrl;
    else if (a == 1) v = m_pre;
    else if (a == 2) v = m_pend;
    else if (a == 3) v = m_status;
    else if (a == 4) v = m_mask;
    else if (a < DEPTH) v = ((a - 5) % 2 == 0) ? m_sp[(a - 5) / 2] : m_sd[(a - 5) / 2];
    return v;
  endfunction

  task automatic model_step();
    int unsigned fire, set_m, clr_m, a;
    a = w_addr;
    exp_rv    = r_en;
    exp_rerr  = r_en && (r_addr >= DEPTH);
    exp_rdata = (r_en && r_addr < DEPTH) ? m_reg(r_addr) : 0;
    exp_ack   = w_en;
    exp_werr  = w_en && (a >= DEPTH);
    exp_irq   = IRQ_EN && ((m_status & m_mask) != 0);
    fire = 0;
    for (int i = 0; i < NCH; i++) begin
      if (m_pend[i] && (pe[i] || !m_ctrl[i+1] || !m_ctrl[0])) begin
        fire[i] = 1'b1;
        m_ap[i] = m_sp[i];
        m_ad[i] = (m_sd[i] < m_sp[i]) ? m_sd[i] : m_sp[i];
      end
    end
    set_m = (w_en && a == 2) ? (w_data & 'hF) : 0;
    clr_m = (w_en && a == 3) ? (w_data & 'hF) : 0;
    if (w_en) begin
      if (a == 0) m_ctrl = w_data & 'h1F;
      else if (a == 1) m_pre = w_data;
      else if (a == 4 && IRQ_EN) m_mask = w_data & 'hF;
      else if (a >= 5 && a < DEPTH) begin
        if ((a - 5) % 2 == 0) m_sp[(a - 5) / 2] = w_data;
        else m_sd[(a - 5) / 2] = w_data;
      end
    end
    m_pend   = (m_pend & ~fire) | set_m;
    m_status = (m_status & ~clr_m) | fire;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("write_ack", write_ack, exp_ack);
    chk("write_err", write_err, exp_werr);
    chk("read_valid", read_valid, exp_rv);
    chk("read_err", read_err, exp_rerr);
    chk("read_data", read_data, exp_rdata);
    chk("irq", irq, exp_irq);
    chk("prescale", prescale, m_pre);
    chk("enable", pwm_enable_reg, m_ctrl);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("period%0d", i), period[i*RW +: RW], m_ap[i]);
      chk($sformatf("duty%0d", i), duty[i*RW +: RW], m_ad[i]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wr(input int a, input int d);
    w_en = 1'b1; w_addr = AW'(a); w_data = RW'(d);
    tick();
    w_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int a, input int exp);
    r_en = 1'b1; r_addr = AW'(a);
    tick();
    r_en = 1'b0;
    chk(name, read_data, exp);
  endtask

  task automatic do_reset();
    w_en = 1'b0; r_en = 1'b0; pe = '0;
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
    logic          err;
  } rd_vec_t;

  rd_vec_t rd_tab[$];

  initial begin
    m_reset();
    for (int a = 0; a < 16; a++) rd_tab.push_back('{addr: AW'(a), data: '0, err: (a >= DEPTH)});

    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Reset-state read sweep, including out-of-range addresses.
    foreach (rd_tab[k]) begin
      r_en = 1'b1; r_addr = rd_tab[k].addr;
      tick();
      chk($sformatf("rst_rd_data_%0d", k), read_data, rd_tab[k].data);
      chk($sformatf("rst_rd_valid_%0d", k), read_valid, 1'b1);
      chk($sformatf("rst_rd_err_%0d", k), read_err, rd_tab[k].err);
    end
    r_en = 1'b0;
    wr(DEPTH, 'h55);
    chk("oob_write_err", write_err, 1'b1);

    // Enabled channel waits for its period boundary.
    wr(0, 'h3); wr(5, 100); wr(6, 40); wr(2, 'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("p0_hold_before_end", period[0 +: RW], 0);
    end
    pe = 4'b0001; tick(); pe = '0;
    chk("p0_loaded", period[0 +: RW], 100);
    chk("d0_loaded", duty[0 +: RW], 40);
    rd_chk("status_after_p0", 3, 'h1);

    // Disabled channel loads without a boundary, duty clamped to period.
    wr(0, 'h1); wr(7, 50); wr(8, 80); wr(2, 'h2);
    chk("p1_not_yet", period[RW +: RW], 0);
    tick();
    chk("p1_loaded", period[RW +: RW], 50);
    chk("d1_clamped", duty[RW +: RW], 50);

    // Load and W1C of the same STATUS bit in one cycle: the set survives.
    wr(3, 'h2);
    rd_chk("status_0x1", 3, 'h1);
    wr(2, 'h1);
    wr(3, 'h1);
    rd_chk("status_set_wins", 3, 'h1);
    wr(3, 'h1);
    rd_chk("status_cleared", 3, 'h0);

    // Shadow write coincident with a load: active takes the old shadow.
    wr(0, 'h3);
    wr(2, 'h1);
    w_en = 1'b1; w_addr = AW'(5); w_data = 200; pe = 4'b0001;
    r_en = 1'b1; r_addr = AW'(5);
    tick();
    w_en = 1'b0; pe = '0; r_en = 1'b0;
    chk("rd_pre_write_value", read_data, 100);
    chk("p0_old_shadow", period[0 +: RW], 100);
    rd_chk("shadow_p0_new", 5, 200);
    wr(2, 'h1);
    pe = 4'b0001; tick(); pe = '0;
    chk("p0_new_shadow", period[0 +: RW], 200);
    chk("d0_after_reload", duty[0 +: RW], 40);

    // Interrupt path.
    wr(3, 'hF); wr(4, 'h1); wr(0, 'h1); wr(2, 'h1);
    tick();
    chk("irq_same_cycle_as_status", irq, 1'b0);
    tick();
    chk("irq_after_status", irq, IRQ_EN);
    wr(3, 'h1);
    tick();
    chk("irq_after_w1c", irq, 1'b0);
    rd_chk("irq_mask_read", 4, IRQ_EN ? 'h1 : 'h0);

    // Reset with a commit outstanding discards it.
    wr(0, 'h3); wr(2, 'h1);
    do_reset();
    chk("p0_zero_after_reset", period[0 +: RW], 0);
    pe = 4'b1111; tick(); pe = '0;
    chk("p0_no_stale_load", period[0 +: RW], 0);
    rd_chk("pending_cleared", 2, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      w_en   = ($urandom_range(0, 2) == 0);
      w_addr = AW'($urandom_range(0, 15));
      w_data = (w_addr == 2 || w_addr == 3) ? RW'($urandom_range(0, 15)) : RW'($urandom_range(0, 300));
      r_en   = ($urandom_range(0, 1) == 0);
      r_addr = AW'($urandom_range(0, 15));
      pe     = NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
      tick();
      if (n == 400) do_reset();
    end
    w_en = 1'b0; r_en = 1'b0; pe = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_regs_shadow.md
Name: pwm_regs_shadow

Overview:
Next-generation PWM register bank, bridging AXI-decoded software accesses and the multi-channel PWM core. Period and duty are double-buffered per channel. Software writes shadow registers, then requests a commit; the active values driven to the core change only at that channel's period boundary, so no glitched PWM cycles occur. Adds write/read error responses, a sticky W1C update-done status, and duty clamping.

Parameters:
REG_WIDTH, 16, register data width
NUM_CHANNELS, 4, PWM channels; legal range 1..REG_WIDTH-1
DEPTH (localparam), 5+2*NUM_CHANNELS, number of register addresses
ADDR_WIDTH (localparam), $clog2(DEPTH), register address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
write_en  in  1  write strobe, single cycle
write_addr  in  ADDR_WIDTH  write register address
write_data  in  REG_WIDTH  write data
write_ack  out  1  pulses 1 cycle after every write_en
write_err  out  1  valid with write_ack; 1 = bad address or read-only target
read_en  in  1  read strobe
read_addr  in  ADDR_WIDTH  read register address
read_data  out  REG_WIDTH  read data; 0 when not valid or on error
read_valid  out  1  pulses 1 cycle after read_en
read_err  out  1  valid with read_valid; 1 = address >= DEPTH
period_end  in  NUM_CHANNELS  per-channel period-boundary pulse from core
prescale  out  REG_WIDTH  prescaler value, direct (not buffered)
period  out  REG_WIDTH x NUM_CHANNELS  active period per channel
duty  out  REG_WIDTH x NUM_CHANNELS  active duty per channel
pwm_enable_reg  out  NUM_CHANNELS+1  bit0 = global enable, bit i+1 = channel i enable
irq  out  1  interrupt (optional feature; tied 0 when compiled out)

Behaviour:
- Address map:
  - 0 CTRL (RW, bits [NUM_CHANNELS:0]; upper bits read 0)
  - 1 PRESCALE (RW)
  - 2 UPDATE (write 1 to bit i = set commit pending for channel i; reads return the pending mask)
  - 3 STATUS (W1C; bit i = channel i loaded)
  - 4 IRQ_MASK (RW, bits [NUM_CHANNELS-1:0])
  - 5+2i PERIOD shadow i (RW)
  - 6+2i DUTY shadow i (RW)
- Reset: all shadow, active, CTRL, PRESCALE, STATUS, IRQ_MASK and pending bits = 0. All outputs = 0, including ack/valid/err and irq. Async assert, sync deassert handled upstream.
- Write: registered in the cycle of write_en. write_ack and write_err assert the next cycle.
  - Address >= DEPTH: no state change, write_err=1.
  - No read-only registers exist in the map; write_err covers range only.
- Read: 1-cycle latency. A read of the same address as a same-cycle write returns the pre-write value.
- Commit, per channel:
  - A pending bit set in cycle N is eligible from N+1.
  - The load fires when pending && (period_end[i] || !pwm_enable_reg[i+1] || !pwm_enable_reg[0]).
  - On load: active period <= shadow period; active duty <= min(shadow duty, shadow period) (unsigned clamp); pending clears; STATUS[i] sets.
- Simultaneous events:
  - Shadow write and load in the same cycle: the load uses the old shadow value.
  - STATUS set and W1C in the same cycle: set wins.
  - UPDATE write to an already-pending channel: no-op.
  - Load and a new UPDATE bit for the same channel in the same cycle: pending stays set, so a second load occurs at the next boundary.
- period_end without pending: no effect.
- Reset mid-commit: pending is discarded and active values are zeroed.

Optional Feature:
PWM_REGS_IRQ_EN
- Defined: irq is registered as |(STATUS & IRQ_MASK) and is 1-cycle delayed from the STATUS change. It clears the cycle after the W1C.
- Undefined: irq is tied 0. IRQ_MASK reads 0, writes are ignored, and write_err stays 0 (address stays in map).

Decomposition:
- pwm_regs_pkg holds:
  - address constants ADDR_CTRL=0, ADDR_PRESCALE=1, ADDR_UPDATE=2, ADDR_STATUS=3, ADDR_IRQ_MASK=4, ADDR_CH_BASE=5
  - functions period_addr(i) and duty_addr(i)
- Sub-module pwm_shadow_ch, one instance per channel via generate. It holds the shadow and active period/duty, the pending flag, the clamp, and the load strobe output.

Test Plan:
- Reset, then read addr 0..DEPTH-1 -> all read_data=0, read_valid=1, read_err=0. Read addr DEPTH -> read_err=1, read_data=0.
- CTRL=0x3, write PERIOD0=100, DUTY0=40, UPDATE=0x1, pulse period_end[0] 5 cycles later -> period[0]=100 and duty[0]=40 on the following cycle, STATUS=0x1. Outputs stay 0 before the pulse.
- Channel 1 disabled (CTRL=0x1), PERIOD1=50, DUTY1=80, UPDATE=0x2 -> load 2 cycles after the UPDATE write without period_end, duty[1]=50 (clamped).
- STATUS=0x1, write STATUS=0x1 in the same cycle as a new load of channel 0 -> STATUS stays 0x1. A W1C with no load -> 0x0.
- Shadow PERIOD0 write coincident with a period_end load -> active takes the old value; the next UPDATE plus period_end loads the new one.
- With PWM_REGS_IRQ_EN: IRQ_MASK=0x1, load channel 0 -> irq=1 one cycle after STATUS sets. W1C STATUS -> irq=0. Without the macro -> irq always 0.
